// File: rtl/cpu_pkg.sv
// Shared CPU constants and helpers for the fetch/decode pipeline.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
  localparam int IM_AW_DEFAULT = 6;

  // J-type target: region bits come from PC+4 of the jump instruction.
  function automatic logic [31:0] jump_target(input logic [3:0] region,
                                              input logic [25:0] idx);
    return {region, idx, 2'b00};
  endfunction

endpackage

// File: rtl/pc_fetch_ifid_reg.sv
// IF/ID pipeline register: reset and bubble clear it, load captures, otherwise hold.
module ifid_reg
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] next_instr,
  input  logic [31:0]        next_pc4,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        pc4,
  output logic               valid
);

  always_ff @(posedge clk) begin
    if (rst || bubble) begin
      instr <= NOP_INSTR;
      pc4   <= 32'h0000_0000;
      valid <= 1'b0;
    end else if (load) begin
      instr <= next_instr;
      pc4   <= next_pc4;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC, next-PC selection and IF/ID capture.
// Optional macro PC_FETCH_BOUND_CHECK_EN adds fetch_fault for PCs outside im.
module pc_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IM_AW    = IM_AW_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  output logic [IM_AW-1:0]   im_addr,
  input  logic [INSTR_W-1:0] im_data,
  input  logic               stall,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  output logic [31:0]        pc,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [31:0]        ifid_pc4,
  output logic               ifid_valid
`ifdef PC_FETCH_BOUND_CHECK_EN
  ,
  output logic               fetch_fault
`endif
);

  logic [31:0] pc_plus4;
  logic [31:0] next_pc;
  logic        redirect;
  logic        fetch;
  logic        load;
  logic        bubble;

  assign im_addr  = pc[IM_AW+1:2];
  assign pc_plus4 = pc + 32'd4;
  assign redirect = branch_taken | jump;
  assign fetch    = !redirect && !stall;

  // Branch is older than the jump in ID, so it takes precedence.
  always_comb begin
    next_pc = pc;
    if (branch_taken)
      next_pc = branch_target & ~32'd3;
    else if (jump)
      next_pc = jump_target(ifid_pc4[31:28], jump_index);
    else if (!stall)
      next_pc = pc_plus4;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pc <= RESET_PC;
    else
      pc <= next_pc;
  end

`ifdef PC_FETCH_BOUND_CHECK_EN
  logic out_of_range;

  // PC keeps advancing out of range; only the latched instruction is suppressed.
  assign out_of_range = |pc[31:IM_AW+2];
  assign load         = fetch && !out_of_range;
  assign bubble       = redirect || (fetch && out_of_range);

  always_ff @(posedge clk) begin
    if (rst)
      fetch_fault <= 1'b0;
    else if (fetch && out_of_range)
      fetch_fault <= 1'b1;
  end
`else
  assign load   = fetch;
  assign bubble = redirect;
`endif

  ifid_reg u_ifid (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .bubble     (bubble),
    .next_instr (im_data),
    .next_pc4   (pc_plus4),
    .instr      (ifid_instr),
    .pc4        (ifid_pc4),
    .valid      (ifid_valid)
  );

endmodule
